// File: rtl/nw_linear_score_engine_if.sv
// Direction-code stream from the NW score engine to a direction store / traceback unit.
// One beat per interior cell, valid/ready handshake, strictly row-major.
interface nw_linear_score_engine_if #(
    parameter int unsigned BitAddr = 8
) ();
    logic               dir_valid;
    logic               dir_ready;
    logic [BitAddr-1:0] dir_i;
    logic [BitAddr-1:0] dir_j;
    logic [2:0]         dir_code;

    modport master (output dir_valid, output dir_i, output dir_j, output dir_code, input dir_ready);
    modport slave  (input dir_valid, input dir_i, input dir_j, input dir_code, output dir_ready);
endinterface

// File: rtl/nw_linear_score_engine.sv
// Linear-space Needleman-Wunsch score engine: one row buffer, run-time scores and lengths,
// streams a direction code per interior cell and reports H(len_a,len_b) on completion.
module nw_linear_score_engine #(
    parameter int unsigned N       = 128,
    parameter int unsigned BitAddr = $clog2(N + 1),
    parameter int unsigned SW      = 12,
    parameter int unsigned SYM_W   = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [BitAddr-1:0]          len_a,
    input  logic [BitAddr-1:0]          len_b,
    input  logic [3:0]                  match_sc,
    input  logic [3:0]                  mismatch_sc,
    input  logic [3:0]                  gap_sc,
    output logic [BitAddr-1:0]          addr_a,
    input  logic [SYM_W-1:0]            dout_a,
    output logic [BitAddr-1:0]          addr_b,
    input  logic [SYM_W-1:0]            dout_b,
    nw_linear_score_engine_if.master    dir,
    output logic                        busy,
    output logic                        done,
    output logic                        err,
    output logic signed [SW-1:0]        final_score
);

    localparam int unsigned        BIdxW  = (N > 1) ? $clog2(N) : 1;
    localparam logic [BitAddr-1:0] LenMax = BitAddr'(N);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD_B  = 3'd1;
    localparam logic [2:0] S_FETCH_A = 3'd2;
    localparam logic [2:0] S_ROW     = 3'd3;
    localparam logic [2:0] S_DRAIN   = 3'd4;
    localparam logic [2:0] S_FINISH  = 3'd5;

    logic [2:0]                state, state_d;
    logic [BitAddr-1:0]        len_a_r, len_b_r, i_r, k_r;
    logic signed [SW-1:0]      match_r, mismatch_r, gap_r;
    logic signed [SW-1:0]      diag_r, left_r, acc_r;
    logic [SYM_W-1:0]          a_sym_r;
    logic                      phase_r, err_flag_r;

    logic [SYM_W-1:0]          b_buf [N];
    logic signed [SW-1:0]      r_buf [N+1];

    logic signed [SW-1:0]      match_ext_c, mismatch_ext_c, gap_ext_c;
    logic signed [SW-1:0]      len_sum_c, zero_score_c, acc_gap_c;
    logic signed [SW-1:0]      sub_c, d_c, u_c, l_c, max_c;
    logic [2:0]                code_c;
    logic [BitAddr-1:0]        jm1_c, k_nx_c;
    logic [SYM_W-1:0]          b_sym_c;
    logic                      len_err_c, len_zero_c, cell_en_c, row_last_c;

    // Job-start decode: sign-extended scores, length checks, empty-matrix score
    assign match_ext_c    = {{(SW-4){match_sc[3]}}, match_sc};
    assign mismatch_ext_c = {{(SW-4){mismatch_sc[3]}}, mismatch_sc};
    assign gap_ext_c      = {{(SW-4){gap_sc[3]}}, gap_sc};
    assign len_err_c      = (len_a > LenMax) || (len_b > LenMax);
    assign len_zero_c     = (len_a == '0) || (len_b == '0);
    assign len_sum_c      = SW'(len_a) + SW'(len_b);
    assign zero_score_c   = len_sum_c * gap_ext_c;

    assign acc_gap_c  = acc_r + gap_r;
    assign k_nx_c     = k_r + BitAddr'(1);
    assign jm1_c      = k_r - BitAddr'(1);
    assign b_sym_c    = b_buf[jm1_c[BIdxW-1:0]];
    assign row_last_c = (k_r == len_b_r);
    assign cell_en_c  = (state == S_ROW) && (!dir.dir_valid || dir.dir_ready);

    // Cell recurrence; ties resolve diag > up > left
    always_comb begin
        sub_c  = (a_sym_r == b_sym_c) ? match_r : mismatch_r;
        d_c    = diag_r + sub_c;
        u_c    = r_buf[k_r] + gap_r;
        l_c    = left_r + gap_r;
        max_c  = l_c;
        code_c = 3'b100;
        if (d_c >= u_c && d_c >= l_c) begin
            max_c  = d_c;
            code_c = 3'b001;
        end else if (u_c >= l_c) begin
            max_c  = u_c;
            code_c = 3'b010;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (len_err_c || len_zero_c) state_d = S_FINISH;
                    else                         state_d = S_LOAD_B;
                end
            end
            S_LOAD_B:  if (row_last_c) state_d = S_FETCH_A;
            S_FETCH_A: if (phase_r)    state_d = S_ROW;
            S_ROW: begin
                if (cell_en_c && row_last_c)
                    state_d = (i_r == len_a_r) ? S_DRAIN : S_FETCH_A;
            end
            S_DRAIN:   if (!dir.dir_valid || dir.dir_ready) state_d = S_FINISH;
            S_FINISH:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Buffers carry no reset: every entry read in a job is written earlier in that job
    always_ff @(posedge clk) begin
        if (state == S_LOAD_B) begin
            r_buf[k_r] <= acc_r;
            if (k_r != '0) b_buf[jm1_c[BIdxW-1:0]] <= dout_b;
        end else if (state == S_FETCH_A && phase_r) begin
            r_buf[0] <= acc_gap_c;
        end else if (cell_en_c) begin
            r_buf[k_r] <= max_c;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_a_r      <= '0;
            len_b_r      <= '0;
            i_r          <= '0;
            k_r          <= '0;
            match_r      <= '0;
            mismatch_r   <= '0;
            gap_r        <= '0;
            diag_r       <= '0;
            left_r       <= '0;
            acc_r        <= '0;
            a_sym_r      <= '0;
            phase_r      <= 1'b0;
            err_flag_r   <= 1'b0;
            addr_a       <= '0;
            addr_b       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            final_score  <= '0;
            dir.dir_valid <= 1'b0;
            dir.dir_i     <= '0;
            dir.dir_j     <= '0;
            dir.dir_code  <= '0;
        end else begin
            done <= 1'b0;
            if (dir.dir_valid && dir.dir_ready) dir.dir_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        len_a_r     <= len_a;
                        len_b_r     <= len_b;
                        match_r     <= match_ext_c;
                        mismatch_r  <= mismatch_ext_c;
                        gap_r       <= gap_ext_c;
                        busy        <= 1'b1;
                        err         <= 1'b0;
                        err_flag_r  <= len_err_c;
                        final_score <= (!len_err_c && len_zero_c) ? zero_score_c : '0;
                        k_r         <= '0;
                        i_r         <= BitAddr'(1);
                        acc_r       <= '0;
                        addr_a      <= '0;
                        addr_b      <= '0;
                    end
                end
                S_LOAD_B: begin
                    // acc_r walks j*gap for the top row, then restarts as the column-0 value
                    if (row_last_c) begin
                        k_r     <= '0;
                        acc_r   <= '0;
                        addr_a  <= '0;
                        addr_b  <= '0;
                        phase_r <= 1'b0;
                    end else begin
                        k_r    <= k_nx_c;
                        acc_r  <= acc_gap_c;
                        addr_b <= (k_nx_c < len_b_r) ? k_nx_c : '0;
                    end
                end
                S_FETCH_A: begin
                    phase_r <= ~phase_r;
                    if (phase_r) begin
                        a_sym_r <= dout_a;
                        acc_r   <= acc_gap_c;
                        left_r  <= acc_gap_c;
                        diag_r  <= r_buf[0];
                        k_r     <= BitAddr'(1);
                    end
                end
                S_ROW: begin
                    if (cell_en_c) begin
                        diag_r        <= r_buf[k_r];
                        left_r        <= max_c;
                        dir.dir_i     <= i_r;
                        dir.dir_j     <= k_r;
                        dir.dir_code  <= code_c;
                        dir.dir_valid <= 1'b1;
                        if (!row_last_c) begin
                            k_r <= k_nx_c;
                        end else if (i_r != len_a_r) begin
                            addr_a  <= i_r;
                            i_r     <= i_r + BitAddr'(1);
                            phase_r <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (!dir.dir_valid || dir.dir_ready) final_score <= r_buf[len_b_r];
                end
                S_FINISH: begin
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    err    <= err_flag_r;
                    addr_a <= '0;
                    addr_b <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
